cpu_bus_sequencer: RTL
======================

// Module: cpu_bus_sequencer
// PURPOSE
//  Multi-beat bus master between the CPU core and the external bus (o_bus_clk strobe / i_bus_data_ready).
//  Core issues one request of 1..MAX_BEATS beats; block walks addresses up (loads/stores) or down
//  (stack pushes, e.g. eDST1 then eDST0), inserts wait states, assembles read data, aborts on timeout.
//  Successor to the single-beat strobe logic: parametrised width/beats, descending mode, watchdog.
// PARAMETERS
//  ADDR_W     32   bus address width
//  DATA_W     8    bits per beat
//  MAX_BEATS  4    max beats per request (>=1)
//  TIMEOUT    255  max wait cycles per beat before abort; 0 = no timeout
// PORTS
//  i_clk            in   1                  clock
//  i_rst            in   1                  reset, synchronous, active-high
//  i_req            in   1                  request; sampled only when o_busy=0
//  i_we             in   1                  1=write, 0=read
//  i_desc           in   1                  1=beat k at i_addr-k, 0=beat k at i_addr+k
//  i_beats          in   clog2(MAX_BEATS)+1 beat count, 1..MAX_BEATS (0 treated as 1)
//  i_addr           in   ADDR_W             address of beat 0
//  i_wdata          in   MAX_BEATS*DATA_W   beat k = [k*DATA_W +: DATA_W]
//  o_busy           out  1                  transfer in progress
//  o_done           out  1                  one-cycle pulse at completion or abort
//  o_timeout        out  1                  one-cycle pulse with o_done on abort
//  o_rdata          out  MAX_BEATS*DATA_W   read beats, same packing; unread beats 0
//  o_bus_clk        out  1                  bus strobe
//  o_bus_we         out  1                  bus write enable
//  o_bus_addr       out  ADDR_W             bus address
//  o_bus_data       out  DATA_W             bus write data
//  i_bus_data       in   DATA_W             bus read data
//  i_bus_data_ready in   1                  bus ack, sampled only while o_bus_clk=1
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0; reset mid-transfer abandons it, no o_done.
//  States: IDLE -> STROBE -> GAP -> (STROBE | IDLE); STROBE -> GAP on timeout.
//  IDLE: edge with i_req=1 latches request, clears o_rdata, o_busy<=1, o_bus_clk<=1, drives beat 0.
//  STROBE: o_bus_clk=1; addr/we/data held stable; each edge with ready=0 increments wait count.
//   ready=1: read -> capture i_bus_data into beat slot; o_bus_clk<=0; -> GAP; wait count cleared.
//   wait count reaches TIMEOUT (TIMEOUT!=0): o_bus_clk<=0, remaining beats dropped, -> GAP(abort).
//  GAP: exactly one cycle with o_bus_clk=0 (bus recovery).
//   more beats and no abort: addr +/-1, next data, o_bus_clk<=1 -> STROBE.
//   else: o_done<=1 (o_timeout<=1 if abort), o_busy<=0 -> IDLE.
//  Latency: zero-wait N beats -> o_done rises 2N+1 edges after request edge; +W per W wait cycles.
//  Address arithmetic modulo 2^ADDR_W (0xFFFFFFFF+1=0, 0-1=0xFFFFFFFF).
//  o_rdata held until next accepted request. i_req while busy ignored (no queueing).
//  ready=1 while o_bus_clk=0 ignored. o_done and new i_req on same edge: request accepted (busy=0).
// STRUCTURE
//  Package cpu_bus_pkg: state enum (IDLE/STROBE/GAP), DIR_ASC/DIR_DESC constants, beat-count type.
//  One sub-module: bus_watchdog (wait counter: clear/enable/expired, TIMEOUT param, 0=disabled).
//  Rest is one FSM + address/beat counters in this module; target ~200 lines.
// TESTING
//  1 read 1 beat @0x1234, mem returns 0xA5 zero-wait -> o_rdata=0x000000A5, o_bus_clk high 1 cycle, o_done 3 edges after req.
//  2 write 4 beats asc @0x01FE data 0x44332211 -> 11@1FE,22@1FF,33@200,44@201, o_done at edge 9, o_timeout=0.
//  3 write 2 beats desc @0x01FF data 0xBBAA -> AA@1FF then BB@1FE; o_bus_clk low between beats.
//  4 read 3 beats, ready delayed 5 cycles/beat -> addr/we stable during waits, o_done at edge 22, data correct.
//  5 TIMEOUT=16, ready never -> o_bus_clk drops after 16 wait edges, o_done&o_timeout pulse next edge, no further beats.
//  6 2 beats asc @0xFFFFFFFF -> second beat @0x0; then i_rst in STROBE -> all outputs 0 next edge, new req served.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_bus_pkg
//  Purpose  : Shared types and constants for the CPU multi-beat bus sequencer.
//             state_t    - sequencer FSM states (IDLE / STROBE / GAP)
//             DIR_ASC    - beat k at base address + k
//             DIR_DESC   - beat k at base address - k (stack pushes)
//             beat_cnt_t - beat index / beat count type (covers up to 255 beats)
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  localparam logic DIR_ASC  = 1'b0;
  localparam logic DIR_DESC = 1'b1;

  typedef logic [7:0] beat_cnt_t;

endpackage
`default_nettype wire

// File: rtl/bus_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : bus_watchdog
//  Purpose  : Per-beat wait-state counter. Counts edges with enable=1 and
//             flags the edge on which the count reaches TIMEOUT.
//  Ports    : clk     in  clock
//             rst     in  synchronous active-high reset
//             clear   in  zero the count (takes priority over enable)
//             enable  in  count this edge as a wait cycle
//             expired out this enabled edge is the TIMEOUT-th wait edge
//  Params   : TIMEOUT - wait edges before expiry; 0 disables expiry
//  Revision : 1.0 - initial release
// ============================================================================
module bus_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  // Expiry is flagged combinationally on the edge that would bring the count
  // to TIMEOUT, so the sequencer can drop the strobe on that same edge.
  assign expired = (TIMEOUT != 0) && enable && (count == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_bus_sequencer
//  Purpose  : Multi-beat bus master between the CPU core and the external bus.
//             One request of 1..MAX_BEATS beats walks addresses up or down,
//             holds the strobe through wait states, assembles read data and
//             aborts a beat that waits TIMEOUT cycles.
//  Ports    : i_clk, i_rst                 clock, synchronous active-high reset
//             i_req/i_we/i_desc/i_beats    request, write, descending, beat count
//             i_addr/i_wdata               beat-0 address, packed write beats
//             o_busy/o_done/o_timeout      status; done/timeout are 1-cycle pulses
//             o_rdata                      packed read beats (unread beats 0)
//             o_bus_clk/o_bus_we           bus strobe and write enable
//             o_bus_addr/o_bus_data        bus address and write data
//             i_bus_data/i_bus_data_ready  bus read data and ack
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_bus_sequencer
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_req,
  input  logic                          i_we,
  input  logic                          i_desc,
  input  logic [$clog2(MAX_BEATS):0]    i_beats,
  input  logic [ADDR_W-1:0]             i_addr,
  input  logic [MAX_BEATS*DATA_W-1:0]   i_wdata,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_timeout,
  output logic [MAX_BEATS*DATA_W-1:0]   o_rdata,
  output logic                          o_bus_clk,
  output logic                          o_bus_we,
  output logic [ADDR_W-1:0]             o_bus_addr,
  output logic [DATA_W-1:0]             o_bus_data,
  input  logic [DATA_W-1:0]             i_bus_data,
  input  logic                          i_bus_data_ready
);

  state_t                       state;
  beat_cnt_t                    beat_idx;
  beat_cnt_t                    beat_total;
  beat_cnt_t                    req_beats;
  logic                         dir;
  logic                         abort;
  logic [MAX_BEATS*DATA_W-1:0]  wdata;
  logic                         busy;
  logic                         done;
  logic                         timeout;
  logic [MAX_BEATS*DATA_W-1:0]  rdata;
  logic                         bus_clk;
  logic                         bus_we;
  logic [ADDR_W-1:0]            bus_addr;
  logic [DATA_W-1:0]            bus_data;
  logic                         wd_clear;
  logic                         wd_enable;
  logic                         wd_expired;

  // A zero count means one beat; oversize counts are clamped so the beat
  // index can never select outside the packed data buses.
  always_comb begin
    req_beats = beat_cnt_t'(i_beats);
    if (req_beats == '0) begin
      req_beats = beat_cnt_t'(1);
    end else if (req_beats > beat_cnt_t'(MAX_BEATS)) begin
      req_beats = beat_cnt_t'(MAX_BEATS);
    end
  end

  // The wait counter only runs while the strobe is up and unanswered.
  assign wd_clear  = (state != ST_STROBE) || i_bus_data_ready;
  assign wd_enable = (state == ST_STROBE) && !i_bus_data_ready;

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (i_clk),
    .rst     (i_rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      beat_idx   <= '0;
      beat_total <= '0;
      dir        <= DIR_ASC;
      abort      <= 1'b0;
      wdata      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      rdata      <= '0;
      bus_clk    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_data   <= '0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_req) begin
            beat_idx   <= '0;
            beat_total <= req_beats;
            dir        <= i_desc;
            abort      <= 1'b0;
            wdata      <= i_wdata;
            rdata      <= '0;
            busy       <= 1'b1;
            bus_clk    <= 1'b1;
            bus_we     <= i_we;
            bus_addr   <= i_addr;
            bus_data   <= i_wdata[DATA_W-1:0];
            state      <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          if (i_bus_data_ready) begin
            if (!bus_we) begin
              rdata[int'(beat_idx)*DATA_W +: DATA_W] <= i_bus_data;
            end
            bus_clk <= 1'b0;
            state   <= ST_GAP;
          end else if (wd_expired) begin
            bus_clk <= 1'b0;
            abort   <= 1'b1;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (!abort && (beat_idx + beat_cnt_t'(1) < beat_total)) begin
            beat_idx <= beat_idx + beat_cnt_t'(1);
            bus_addr <= (dir == DIR_DESC) ? bus_addr - ADDR_W'(1)
                                          : bus_addr + ADDR_W'(1);
            bus_data <= wdata[(int'(beat_idx) + 1)*DATA_W +: DATA_W];
            bus_clk  <= 1'b1;
            state    <= ST_STROBE;
          end else begin
            done    <= 1'b1;
            timeout <= abort;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          bus_clk <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy     = busy;
  assign o_done     = done;
  assign o_timeout  = timeout;
  assign o_rdata    = rdata;
  assign o_bus_clk  = bus_clk;
  assign o_bus_we   = bus_we;
  assign o_bus_addr = bus_addr;
  assign o_bus_data = bus_data;

endmodule
`default_nettype wire
